// File: rtl/n64_poll_controller.sv
// n64_poll_controller: polls an N64 controller over the open-drain one-wire link and publishes the decoded 32-bit reply.
module n64_poll_controller #(
  parameter int US_CYCLES   = 12,
  parameter int TIMEOUT_US  = 200,
  parameter int POLL_PERIOD = 200000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        poll_en,
  input  logic        data_in,
  output logic        data_oe,
  output logic        busy,
  output logic        valid,
  output logic        err,
  output logic [15:0] buttons,
  output logic [7:0]  joy_x,
  output logic [7:0]  joy_y
);
  localparam int BIT_CYC = 4 * US_CYCLES;
  localparam int TO_CYC  = TIMEOUT_US * US_CYCLES;
  localparam int CW      = $clog2(BIT_CYC);
  localparam int TW      = $clog2(TO_CYC + 1);
  localparam int PW      = $clog2(POLL_PERIOD + 1);
  typedef enum logic [2:0] {S_IDLE, S_TX, S_WAIT_EDGE, S_SAMPLE, S_WAIT_HIGH, S_DONE, S_ERROR} state_t;
  state_t        state_q, state_d;
  logic [1:0]    sync_q, sync_d;
  logic          prev_q, prev_d;
  logic [PW-1:0] poll_q, poll_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    tbit_q, tbit_d;
  logic [TW-1:0] to_q, to_d, to_inc;
  logic [5:0]    bits_q, bits_d;
  logic [31:0]   sr_q, sr_d;
  logic          data_oe_q, data_oe_d, busy_q, busy_d, valid_q, valid_d, err_q, err_d;
  logic [15:0]   buttons_q, buttons_d;
  logic [7:0]    joy_x_q, joy_x_d, joy_y_q, joy_y_d;
  logic          fall, tx_last;
  always_comb begin
    sync_d    = {sync_q[0], data_in};
    prev_d    = sync_q[1];
    fall      = prev_q & ~sync_q[1];
    to_inc    = to_q + TW'(1);
    tx_last   = cnt_q == (tbit_q == 4'd8 ? CW'(US_CYCLES - 1) : CW'(BIT_CYC - 1));
    state_d   = state_q;
    poll_d    = poll_q;
    cnt_d     = cnt_q;
    tbit_d    = tbit_q;
    to_d      = '0;
    bits_d    = bits_q;
    sr_d      = sr_q;
    buttons_d = buttons_q;
    joy_x_d   = joy_x_q;
    joy_y_d   = joy_y_q;
    case (state_q)
      S_IDLE: begin
        poll_d = poll_en ? poll_q + PW'(1) : poll_q;
        if (start || (poll_en && poll_q == PW'(POLL_PERIOD - 1))) begin
          state_d = S_TX;
          poll_d  = '0;
          cnt_d   = '0;
          tbit_d  = '0;
          bits_d  = '0;
        end
      end
      S_TX: begin
        cnt_d  = tx_last ? '0 : cnt_q + CW'(1);
        tbit_d = tx_last ? tbit_q + 4'd1 : tbit_q;
        if (tx_last && tbit_q == 4'd8) state_d = S_WAIT_EDGE;
      end
      S_WAIT_EDGE: begin
        to_d  = to_inc;
        cnt_d = '0;
        if (fall) state_d = S_SAMPLE;
        else if (to_inc == TW'(TO_CYC)) state_d = S_ERROR;
      end
      // sample mid-eye: 2 us after the detected edge splits the 1 us / 3 us low times
      S_SAMPLE: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(2 * US_CYCLES - 1)) begin
          sr_d    = {sr_q[30:0], sync_q[1]};
          bits_d  = bits_q + 6'd1;
          state_d = S_WAIT_HIGH;
        end
      end
      S_WAIT_HIGH: begin
        to_d = sync_q[1] ? '0 : to_inc;
        if (sync_q[1]) state_d = bits_q == 6'd32 ? S_DONE : S_WAIT_EDGE;
        else if (to_inc == TW'(TO_CYC)) state_d = S_ERROR;
        if (sync_q[1] && bits_q == 6'd32) begin
          buttons_d = sr_q[31:16];
          joy_x_d   = sr_q[15:8];
          joy_y_d   = sr_q[7:0];
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERROR: begin
        state_d = S_IDLE;
        bits_d  = '0;
      end
      default: state_d = S_IDLE;
    endcase
    data_oe_d = state_d == S_TX && cnt_d < (tbit_d < 4'd7 ? CW'(3 * US_CYCLES) : CW'(US_CYCLES));
    busy_d    = !(state_d inside {S_IDLE, S_DONE});
    valid_d   = state_d == S_DONE;
    err_d     = state_d == S_ERROR;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      sync_q    <= 2'b11;
      prev_q    <= 1'b1;
      poll_q    <= '0;
      cnt_q     <= '0;
      tbit_q    <= '0;
      to_q      <= '0;
      bits_q    <= '0;
      sr_q      <= '0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      buttons_q <= '0;
      joy_x_q   <= '0;
      joy_y_q   <= '0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      prev_q    <= prev_d;
      poll_q    <= poll_d;
      cnt_q     <= cnt_d;
      tbit_q    <= tbit_d;
      to_q      <= to_d;
      bits_q    <= bits_d;
      sr_q      <= sr_d;
      data_oe_q <= data_oe_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      buttons_q <= buttons_d;
      joy_x_q   <= joy_x_d;
      joy_y_q   <= joy_y_d;
    end
  end
  assign data_oe = data_oe_q;
  assign busy    = busy_q;
  assign valid   = valid_q;
  assign err     = err_q;
  assign buttons = buttons_q;
  assign joy_x   = joy_x_q;
  assign joy_y   = joy_y_q;
endmodule

// File: tb/tb_n64_poll_controller.sv
// tb_n64_poll_controller: randomized request/response traffic against a cycle-schedule model of the poll protocol.
module tb_n64_poll_controller;
  localparam int U   = 4;
  localparam int TO  = 20;
  localparam int PP  = 1000;
  localparam int T   = U * TO;
  localparam int BIG = 1 << 30;
  logic clock = 0, reset = 1, start = 0, poll_en = 0, ctrl = 1;
  logic data_in, data_oe, busy, valid, err;
  logic [15:0] buttons;
  logic [7:0] joy_x, joy_y;
  int cyc = 0, total = 0, bad = 0;
  int ts = BIG, te = BIG, cut = BIG, kind = 0;
  logic [31:0] pending = 0, shown = 0, last = 0;
  assign data_in = ctrl & ~data_oe;
  n64_poll_controller #(.US_CYCLES(U), .TIMEOUT_US(TO), .POLL_PERIOD(PP)) dut (
    .clock(clock), .reset(reset), .start(start), .poll_en(poll_en), .data_in(data_in),
    .data_oe(data_oe), .busy(busy), .valid(valid), .err(err),
    .buttons(buttons), .joy_x(joy_x), .joy_y(joy_y)
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask
  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clock);
      #1;
    end
  endtask
  // model: a poll occupies [ts, te]; te carries a valid (kind 1) or err (kind 2) pulse; reset at cut aborts it
  always @(negedge clock) begin
    int off;
    logic live, eo, eb, ev, ee;
    if (cyc >= 1) begin
      live = cyc >= ts && cyc < cut;
      off  = cyc - ts;
      eo   = live && off < 33 * U && ((off / (4 * U) < 7) ? (off % (4 * U) < 3 * U) : (off % (4 * U) < U));
      eb   = live && (cyc < te || (cyc == te && kind == 2));
      ev   = live && cyc == te && kind == 1;
      ee   = live && cyc == te && kind == 2;
      if (cyc == cut) shown = 0;
      if (ev) shown = pending;
      chk("data_oe", 32'(data_oe), 32'(eo));
      chk("busy", 32'(busy), 32'(eb));
      chk("valid", 32'(valid), 32'(ev));
      chk("err", 32'(err), 32'(ee));
      chk("frame", {buttons, joy_x, joy_y}, shown);
    end
  end
  task automatic kick();
    start = 1;
    ts = cyc + 1;
    te = BIG;
    kind = 0;
    cut = BIG;
    @(posedge clock);
    #1;
    start = 0;
  endtask
  // controller side: 32 bits MSB first, optionally held low from bit 'stuck', optional start pulse at bit 'sb'
  task automatic reply(input logic [31:0] data, input int d, input int stuck, input int sb);
    int e, k0, k, l;
    e = ts + 33 * U;
    k0 = e + d;
    if (stuck < 0) begin
      k = k0 + 124 * U;
      l = data[0] ? U : 3 * U;
      te = (k + l + 2 > k + 2 * U + 3 ? k + l + 2 : k + 2 * U + 3) + 1;
      kind = 1;
      pending = data;
    end else begin
      te = k0 + 4 * U * stuck + 2 * U + 3 + T;
      kind = 2;
    end
    for (int i = 0; i < 32; i++) begin
      k = k0 + 4 * U * i;
      l = data[31-i] ? U : 3 * U;
      wait_cyc(k);
      ctrl = 0;
      start = (i == sb);
      if (i == stuck) begin
        wait_cyc(te + 2);
        ctrl = 1;
        start = 0;
        return;
      end
      wait_cyc(k + l);
      ctrl = 1;
      start = 0;
    end
    wait_cyc(k0 + 128 * U);
    ctrl = 0;
    wait_cyc(k0 + 129 * U);
    ctrl = 1;
    wait_cyc(k0 + 132 * U);
  endtask
  initial begin
    int offs[11] = '{0, 11, 12, 15, 16, 112, 115, 116, 127, 128, 132};
    logic exps[11] = '{1, 1, 0, 0, 1, 1, 1, 0, 0, 1, 0};
    logic [31:0] data;
    repeat (3) @(posedge clock);
    #1;
    reset = 0;
    chk("reset_busy", 32'(busy), 0);
    chk("reset_oe", 32'(data_oe), 0);
    chk("reset_valid", 32'(valid), 0);
    chk("reset_err", 32'(err), 0);
    chk("reset_frame", {buttons, joy_x, joy_y}, 0);
    wait_cyc(cyc + 2);
    kick();
    for (int i = 0; i < 11; i++) begin
      wait_cyc(ts + offs[i]);
      chk("tx_shape", 32'(data_oe), 32'(exps[i]));
    end
    reply(32'h80007F81, 8, -1, -1);
    chk("lit_buttons", 32'(buttons), 32'h8000);
    chk("lit_joy_x", 32'(joy_x), 32'h7F);
    chk("lit_joy_y", 32'(joy_y), 32'h81);
    last = 32'h80007F81;
    for (int n = 0; n < 6; n++) begin
      data = $urandom;
      wait_cyc(cyc + 3);
      kick();
      reply(data, $urandom_range(2, 8 * U), -1, ($urandom_range(0, 2) == 0) ? $urandom_range(0, 31) : -1);
      last = data;
    end
    wait_cyc(cyc + 3);
    kick();
    te = ts + 33 * U + T;
    kind = 2;
    wait_cyc(te + 1);
    chk("timeout_busy", 32'(busy), 0);
    chk("timeout_keep", {buttons, joy_x, joy_y}, last);
    wait_cyc(cyc + 3);
    kick();
    reply($urandom, $urandom_range(2, 8 * U), 10, -1);
    chk("stuck_keep", {buttons, joy_x, joy_y}, last);
    wait_cyc(cyc + 3);
    poll_en = 1;
    ts = cyc + PP;
    te = BIG;
    kind = 0;
    cut = BIG;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        wait_cyc(ts - 1);
        start = 1;
        wait_cyc(ts);
        start = 0;
      end
      data = $urandom;
      reply(data, $urandom_range(2, 8 * U), -1, -1);
      if (i < 2) begin
        ts = te + 1 + PP;
        te = BIG;
        kind = 0;
      end
    end
    poll_en = 0;
    wait_cyc(cyc + 5);
    kick();
    wait_cyc(ts + 50);
    reset = 1;
    cut = cyc + 1;
    wait_cyc(cyc + 1);
    reset = 0;
    chk("midtx_oe", 32'(data_oe), 0);
    chk("midtx_busy", 32'(busy), 0);
    chk("midtx_frame", {buttons, joy_x, joy_y}, 0);
    wait_cyc(cyc + 5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #2000000;
    bad++;
    $display("FAIL watchdog at cycle %0d: got running expected finished", cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
